// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request, shifter and result signals of the shift sequencer
interface shift_sequencer_if #(
  parameter int NBITS = 4,
  parameter int CNTW  = 3
);
  logic             start;
  logic [NBITS-1:0] din;
  logic [2:0]       op;
  logic [CNTW-1:0]  count;
  logic             ready;
  logic             busy;
  logic [NBITS-1:0] sh_a;
  logic [2:0]       sh_op;
  logic [NBITS-1:0] sh_q;
  logic             sh_c;
  logic [NBITS-1:0] dout;
  logic             cout;
  logic             done;
  logic             err;

  modport master (
    output start, din, op, count, sh_q, sh_c,
    input  ready, busy, sh_a, sh_op, dout, cout, done, err
  );

  modport slave (
    input  start, din, op, count, sh_q, sh_c,
    output ready, busy, sh_a, sh_op, dout, cout, done, err
  );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - steps an external one-bit shifter COUNT times over a captured operand
module shift_sequencer #(
  parameter int NBITS = 4,
  parameter int CNTW  = 3
) (
  input logic             clk,
  input logic             rst_n,
  shift_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t           state;
  logic [NBITS-1:0] acc;
  logic [2:0]       opreg;
  logic [CNTW-1:0]  rem;
  logic             carry;
  logic [NBITS-1:0] dout_r;
  logic             cout_r;
  logic             done_r;
  logic             err_r;
  logic             ready_r;
  logic             busy_r;
  logic             op_valid;

  assign op_valid = (bus.op[2:1] != 2'b11);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      opreg   <= '0;
      rem     <= '0;
      carry   <= 1'b0;
      dout_r  <= '0;
      cout_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            acc     <= bus.din;
            opreg   <= bus.op;
            rem     <= bus.count;
            carry   <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            // Nothing to step: result is the operand itself, no carry.
            if (!op_valid || bus.count == '0) begin
              state  <= FINISH;
              done_r <= 1'b1;
              dout_r <= bus.din;
              cout_r <= 1'b0;
              err_r  <= !op_valid;
            end else begin
              state <= SHIFT;
              err_r <= 1'b0;
            end
          end
        end
        SHIFT: begin
          acc   <= bus.sh_q;
          carry <= bus.sh_c;
          rem   <= rem - 1'b1;
          if (rem == CNTW'(1)) begin
            state  <= FINISH;
            done_r <= 1'b1;
            dout_r <= bus.sh_q;
            cout_r <= bus.sh_c;
          end
        end
        FINISH: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sh_a  = acc;
  assign bus.sh_op = opreg;
  assign bus.dout  = dout_r;
  assign bus.cout  = cout_r;
  assign bus.done  = done_r;
  assign bus.err   = err_r;
  assign bus.ready = ready_r;
  assign bus.busy  = busy_r;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer with a modelled one-bit shifter
module tb_shift_sequencer;
  localparam int NB = 4;
  localparam int CW = 3;

  typedef struct {
    logic [NB-1:0] dout;
    logic          cout;
    logic          err;
    int            lat;
  } exp_t;

  logic   clk;
  logic   rst_n;
  int     checks;
  int     errors;
  exp_t   sbq[$];
  logic [NB:0] shv;

  shift_sequencer_if #(.NBITS(NB), .CNTW(CW)) sif ();

  shift_sequencer #(.NBITS(NB), .CNTW(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif)
  );

  always #5 clk = ~clk;

  function automatic logic [NB:0] shift1(input logic [NB-1:0] a, input logic [2:0] o);
    case (o)
      3'd0, 3'd2: return {a[NB-1], a[NB-2:0], 1'b0};
      3'd1:       return {a[0], a[NB-1], a[NB-1:1]};
      3'd3:       return {a[0], 1'b0, a[NB-1:1]};
      3'd4:       return {a[NB-1], a[NB-2:0], a[NB-1]};
      3'd5:       return {a[0], a[0], a[NB-1:1]};
      default:    return {1'b0, a};
    endcase
  endfunction

  // Combinational shifter attached to the sequencer.
  always_comb shv = shift1(sif.sh_a, sif.sh_op);
  assign sif.sh_c = shv[NB];
  assign sif.sh_q = shv[NB-1:0];

  // Called at a negedge; starts one sequence and checks it through the following idle cycle.
  task automatic run_seq(input logic [NB-1:0] d, input logic [2:0] o, input logic [CW-1:0] n,
                         input bit disturb, input string name);
    logic [NB-1:0] acc_m [0:7];
    logic [NB:0]   r;
    logic          c_m;
    bit            valid;
    bit            got;
    int            cycles;
    int            w;
    int            k;
    exp_t          e;
    valid = (o[2:1] != 2'b11);
    acc_m[0] = d;
    c_m = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      if (valid && i <= int'(n)) begin
        r = shift1(acc_m[i-1], o);
        acc_m[i] = r[NB-1:0];
        c_m = r[NB];
      end else begin
        acc_m[i] = acc_m[i-1];
      end
    end
    w = 0;
    while (!sif.ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (sif.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait got=%b want=1", name, sif.ready);
    end
    sif.start = 1'b1;
    sif.din = d;
    sif.op = o;
    sif.count = n;
    e.dout = (valid && n != 0) ? acc_m[n] : d;
    e.cout = (valid && n != 0) ? c_m : 1'b0;
    e.err  = !valid;
    e.lat  = (valid && n != 0) ? int'(n) + 1 : 1;
    sbq.push_back(e);
    got = 0;
    cycles = 0;
    while (cycles < 40 && !got) begin
      @(negedge clk);
      cycles++;
      sif.start = 1'b0;
      if (disturb && cycles == 2) begin
        sif.start = 1'b1;
        sif.din = 4'b1111;
        sif.op = 3'b000;
        sif.count = 3'd1;
      end
      k = (cycles - 1 < int'(n)) ? cycles - 1 : int'(n);
      checks++;
      if (sif.sh_a !== acc_m[k] || sif.sh_op !== o || sif.busy !== 1'b1) begin
        errors++;
        $display("FAIL %s step%0d sh_a=%b sh_op=%b busy=%b want %b %b 1",
                 name, cycles, sif.sh_a, sif.sh_op, sif.busy, acc_m[k], o);
      end
      if (sif.done === 1'b1) got = 1;
    end
    sif.start = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done_timeout got=none want=cycle %0d", name, e.lat);
    end else if (cycles != e.lat || sif.dout !== e.dout || sif.cout !== e.cout || sif.err !== e.err) begin
      errors++;
      $display("FAIL %s result lat=%0d dout=%b cout=%b err=%b want %0d %b %b %b",
               name, cycles, sif.dout, sif.cout, sif.err, e.lat, e.dout, e.cout, e.err);
    end
    @(negedge clk);
    checks++;
    if (sif.ready !== 1'b1 || sif.done !== 1'b0 || sif.busy !== 1'b0 ||
        sif.dout !== e.dout || sif.err !== e.err || sif.sh_a !== e.dout) begin
      errors++;
      $display("FAIL %s after ready=%b done=%b busy=%b dout=%b err=%b sh_a=%b want 1 0 0 %b %b %b",
               name, sif.ready, sif.done, sif.busy, sif.dout, sif.err, sif.sh_a, e.dout, e.err, e.dout);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sif.ready !== 1'b1 || sif.busy !== 1'b0 || sif.done !== 1'b0 || sif.dout !== '0 ||
        sif.cout !== 1'b0 || sif.err !== 1'b0 || sif.sh_a !== '0 || sif.sh_op !== '0) begin
      errors++;
      $display("FAIL reset_state ready=%b busy=%b done=%b dout=%b cout=%b err=%b sh_a=%b sh_op=%b want 1 0 0 0000 0 0 0000 000",
               sif.ready, sif.busy, sif.done, sif.dout, sif.cout, sif.err, sif.sh_a, sif.sh_op);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_priority();
    rst_n = 1'b0;
    sif.start = 1'b1;
    sif.din = 4'b1010;
    sif.op = 3'b010;
    sif.count = 3'd3;
    @(negedge clk);
    checks++;
    if (sif.ready !== 1'b1 || sif.busy !== 1'b0 || sif.sh_a !== '0 || sif.sh_op !== '0) begin
      errors++;
      $display("FAIL reset_priority ready=%b busy=%b sh_a=%b sh_op=%b want 1 0 0000 000",
               sif.ready, sif.busy, sif.sh_a, sif.sh_op);
    end
    rst_n = 1'b1;
    sif.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_seq(4'b1011, 3'b010, 3'd2, 0, "logic_left_2");
    run_seq(4'b0001, 3'b101, 3'd1, 0, "rotate_right_1");
    run_seq(4'b1001, 3'b011, 3'd0, 0, "count_zero");
    run_seq(4'b0110, 3'b110, 3'd3, 0, "invalid_op110");
    run_seq(4'b1101, 3'b111, 3'd0, 0, "invalid_op111");
    run_seq(4'b1010, 3'b001, 3'd3, 0, "arith_right_3");
    run_seq(4'b0101, 3'b000, 3'd2, 0, "arith_left_2");
  endtask

  task automatic test_max_count();
    run_seq(4'b1000, 3'b100, 3'd7, 1, "rotate_left_7_ignore_start");
  endtask

  task automatic test_reset_mid();
    sif.start = 1'b1;
    sif.din = 4'b0110;
    sif.op = 3'b011;
    sif.count = 3'd5;
    @(negedge clk);
    sif.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (sif.ready !== 1'b1 || sif.busy !== 1'b0 || sif.done !== 1'b0 || sif.dout !== '0 ||
        sif.cout !== 1'b0 || sif.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid ready=%b busy=%b done=%b dout=%b cout=%b err=%b want 1 0 0 0000 0 0",
               sif.ready, sif.busy, sif.done, sif.dout, sif.cout, sif.err);
    end
    run_seq(4'b0011, 3'b010, 3'd3, 0, "after_reset_mid");
  endtask

  task automatic test_back_to_back();
    logic [2:0] o;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 7));
      run_seq(4'($urandom), o, 3'($urandom), 0, $sformatf("b2b_%0d", i));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    sif.start = 1'b0;
    sif.din = '0;
    sif.op = '0;
    sif.count = '0;
    test_reset();
    test_reset_priority();
    test_directed();
    test_max_count();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter NBITS, default 4: data width; shall match the width of the attached shifter.
REQ-002 Parameter CNTW, default 3: width of the shift-count input.
REQ-003 CLK  input  1: single clock; all state changes occur on the rising edge.
REQ-004 RST_N  input  1: reset, synchronous and active-low.
REQ-005 START  input  1: request to begin a sequence; accepted only on an edge where READY=1.
REQ-006 DIN  input  NBITS: operand, captured on accept.
REQ-007 OP  input  3: shift opcode, captured on accept. 000 arith-left, 001 arith-right, 010 logic-left, 011 logic-right, 100 rotate-left, 101 rotate-right, 110/111 invalid.
REQ-008 COUNT  input  CNTW: number of single-bit shift steps, captured on accept.
REQ-009 READY  output  1: high only in IDLE.
REQ-010 BUSY  output  1: high in SHIFT and FINISH.
REQ-011 SH_A  output  NBITS: operand driven to the combinational shifter; equals the accumulator register.
REQ-012 SH_OP  output  3: opcode driven to the shifter; equals the captured opcode register.
REQ-013 SH_Q  input  NBITS: shifter result, consumed in the same cycle.
REQ-014 SH_C  input  1: shifter carry-out, consumed in the same cycle.
REQ-015 DOUT  output  NBITS: final result; holds until the next accept or reset.
REQ-016 COUT  output  1: carry from the last executed step; 0 if no step executed.
REQ-017 DONE  output  1: one-cycle completion pulse.
REQ-018 ERR  output  1: high with DONE when the captured opcode was invalid; holds with DOUT.

Function
REQ-019 FSM states: IDLE, SHIFT, FINISH; no other states are reachable.
REQ-020 IDLE, START=1, valid OP, COUNT>0: on that edge E0 capture acc=DIN, opreg=OP, rem=COUNT, carry=0, ERR=0; go to SHIFT.
REQ-021 IDLE, START=1, COUNT=0 or invalid OP: capture as REQ-020; set ERR=1 if OP invalid; go directly to FINISH.
REQ-022 SHIFT, each edge: acc<=SH_Q, carry<=SH_C, rem<=rem-1; when rem=1 on that edge, go to FINISH.
REQ-023 Step k of COUNT occurs at edge Ek (k=1..COUNT); no step on E0.
REQ-024 FINISH: DONE=1 for exactly one cycle; DOUT=acc, COUT=carry are valid there and held afterwards; next edge goes to IDLE.
REQ-025 Latency: DONE is high in the cycle after E_COUNT (the cycle after E0 when COUNT=0 or OP is invalid); READY is high again one cycle later.
REQ-026 START while BUSY=1 is ignored; DIN, OP and COUNT are not sampled.
REQ-027 Input changes after accept do not affect the running sequence.
REQ-028 Invalid opcode: no shift step executes; DOUT=DIN, COUT=0, ERR=1.
REQ-029 COUNT at maximum (2^CNTW-1) executes exactly that many steps; the counter does not wrap early.
REQ-030 In IDLE, SH_A holds the last acc and SH_OP the last opreg; the shifter output is ignored.

Reset
REQ-031 RST_N=0 at an edge: state=IDLE; acc, opreg, rem, carry, DOUT, COUT, DONE and ERR all 0; READY=1 and BUSY=0 from the next cycle.
REQ-032 Reset mid-sequence aborts the sequence; no DONE pulse; the partial result is discarded.
REQ-033 Reset has priority over START on the same edge.

Verification
REQ-034 DIN=1011, OP=010, COUNT=2 -> steps give 0110/C=1, then 1100/C=0; DONE 3rd cycle after accept; DOUT=1100, COUT=0, ERR=0.
REQ-035 DIN=0001, OP=101, COUNT=1 -> DOUT=1000, COUT=1; DONE in the cycle after E1.
REQ-036 DIN=1001, OP=011, COUNT=0 -> DONE in the cycle after E0, DOUT=1001, COUT=0; a second case with OP=110 -> DOUT=DIN, ERR=1.
REQ-037 DIN=1000, OP=100, COUNT=7 -> 7 steps give DOUT=0100, COUT=0; START pulsed mid-sequence with DIN=1111 is ignored.
REQ-038 RST_N=0 at E2 of a COUNT=5 run -> no DONE pulse, DOUT=0, READY=1; a new START on the following edge runs normally.
